// File: rtl/chord_result_buffer.sv
// chord_result_buffer
//
// Downstream stage of the CHORD CORDIC core. Every result word the core emits
// on its valid pulse is captured in a first-word-fall-through FIFO and drained
// through a valid/ready handshake. Upstream credits are issued so that the
// words in flight in the core plus the words held in the FIFO never exceed the
// FIFO depth. This keeps results from being dropped while upstream behaves.
//
// Parameters:
//   DATA_WIDTH  result word width
//   DEPTH       FIFO entries (power of two, >= 2)
//   ADDR_WIDTH  log2(DEPTH)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   issue_valid   upstream is sending a word into the core this cycle
//   issue_ready   a credit is available; upstream may assert issue_valid
//   res_data      core result word
//   res_valid     core result strobe (one-cycle pulse per result)
//   rd_data       head-of-FIFO word (combinational read)
//   rd_valid      FIFO not empty
//   rd_ready      consumer accepts rd_data this cycle
//   overflow      sticky: a result arrived while full and was dropped
//   protocol_err  sticky: issue without credit, or result with nothing in flight
//   level         (CHORD_RB_LEVEL_EN only) current FIFO occupancy
//   credits       (CHORD_RB_LEVEL_EN only) DEPTH - inflight - count
//   clear_err     synchronous clear of both sticky flags
//
// Configuration macro:
//   CHORD_RB_LEVEL_EN  adds the level and credits output ports. The internal
//                      counters are the same with or without it.

module chord_result_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  overflow,
    output logic                  protocol_err,
`ifdef CHORD_RB_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   credits,
`endif
    input  logic                  clear_err
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage is deliberately not reset; only the pointers and counters are.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   inflight_q, inflight_d;
    logic                  overflow_q, overflow_d;
    logic                  protocol_err_q, protocol_err_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  issue;
    logic                  bad_issue;
    logic                  unsolicited;
    logic [ADDR_WIDTH+1:0] occupancy;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        full = (count_q == FULL_COUNT);
        pop  = rd_valid && rd_ready;
        // A pop in the same cycle frees the head slot, so a full FIFO can still
        // accept a result when it is being read.
        push = res_valid && (!full || pop);
        drop = res_valid && full && !pop;

        // Extra bit: an unsolicited result can push the sum past DEPTH.
        occupancy   = {1'b0, inflight_q} + {1'b0, count_q};
        issue_ready = (occupancy < {1'b0, FULL_COUNT});

        issue       = issue_valid && issue_ready;
        bad_issue   = issue_valid && !issue_ready;
        unsolicited = res_valid && (inflight_q == '0);
    end

    // ------------------------------------------------------------------
    // Pointer, occupancy and credit next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A result retires a word even when it is dropped, so inflight tracks
    // res_valid rather than push. Both ends saturate so a misbehaving upstream
    // cannot wrap the counter.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue, res_valid})
            2'b10: begin
                if (inflight_q != FULL_COUNT) begin
                    inflight_d = inflight_q + (ADDR_WIDTH + 1)'(1);
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - (ADDR_WIDTH + 1)'(1);
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new error in the clearing cycle wins
    // ------------------------------------------------------------------
    always_comb begin
        overflow_d     = overflow_q;
        protocol_err_d = protocol_err_q;

        if (clear_err) begin
            overflow_d     = 1'b0;
            protocol_err_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (bad_issue || unsolicited) begin
            protocol_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= '0;
            overflow_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            overflow_q     <= overflow_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= res_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data      = mem[rd_ptr_q];
    assign rd_valid     = (count_q != '0);
    assign overflow     = overflow_q;
    assign protocol_err = protocol_err_q;

`ifdef CHORD_RB_LEVEL_EN
    assign level   = count_q;
    assign credits = FULL_COUNT - inflight_q - count_q;
`endif

endmodule

// File: tb/tb_chord_result_buffer.sv
module tb_chord_result_buffer;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        overflow;
    logic        protocol_err;
    logic        clear_err;
`ifdef CHORD_RB_LEVEL_EN
    logic [3:0]  level;
    logic [3:0]  credits;
`endif

    int checks   = 0;
    int failures = 0;

    chord_result_buffer #(
        .DATA_WIDTH(32),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .overflow    (overflow),
        .protocol_err(protocol_err),
`ifdef CHORD_RB_LEVEL_EN
        .level       (level),
        .credits     (credits),
`endif
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Two solicited results, then one unsolicited to set protocol_err.
        issue_valid = 1'b1;
        tick();
        tick();
        issue_valid = 1'b0;
        res_valid = 1'b1;
        res_data  = 32'h1;
        tick();
        res_data  = 32'h2;
        tick();
        res_data  = 32'h3;
        tick();
        res_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_rd_valid: got %b expected 1", rd_valid);
        end
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_protocol_err: got %b expected 1", protocol_err);
        end
        // Assert reset between edges and check before any edge arrives.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_issue_ready: got %b expected 1", issue_ready);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        checks++;
        if (protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_protocol_err: got %b expected 0", protocol_err);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: got rd_valid=%b issue_ready=%b expected 0/1",
                     rd_valid, issue_ready);
        end
    endtask

    task automatic test_credit_limit();
        int early_drop = 0;
        rd_ready    = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (issue_ready !== 1'b1) early_drop++;
            tick();
        end
        issue_valid = 1'b0;
        checks++;
        if (early_drop != 0) begin
            failures++;
            $display("FAIL credit_early_drop: got %0d cycles not ready expected 0", early_drop);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL credit_exhausted: got issue_ready=%b expected 0", issue_ready);
        end
        for (int i = 0; i < 8; i++) begin
            res_valid = 1'b1;
            res_data  = 32'hA0 + 32'(i);
            tick();
        end
        res_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA0) begin
            failures++;
            $display("FAIL credit_full_head: got rd_valid=%b rd_data=%h expected 1/000000a0",
                     rd_valid, rd_data);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL credit_full_ready: got issue_ready=%b expected 0", issue_ready);
        end
        checks++;
        if (protocol_err !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL credit_no_err: got perr=%b ovf=%b expected 0/0",
                     protocol_err, overflow);
        end
    endtask

    task automatic test_full_pop();
        res_valid = 1'b1;
        res_data  = 32'hB0;
        rd_ready  = 1'b1;
        #1;
        checks++;
        if (rd_data !== 32'hA0) begin
            failures++;
            $display("FAIL full_pop_head_before: got %h expected 000000a0", rd_data);
        end
        tick();
        res_valid = 1'b0;
        rd_ready  = 1'b0;
        checks++;
        if (rd_data !== 32'hA1 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_head_after: got %h valid=%b expected 000000a1/1",
                     rd_data, rd_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_overflow: got %b expected 0", overflow);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_still_full: got issue_ready=%b expected 0", issue_ready);
        end
        // Result was unsolicited (nothing in flight) so protocol_err is set.
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_perr: got %b expected 1", protocol_err);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q [8];
        for (int i = 0; i < 7; i++) exp_q[i] = 32'hA1 + 32'(i);
        exp_q[7] = 32'hB0;
        rd_ready  = 1'b0;
        res_valid = 1'b1;
        res_data  = 32'hDEAD_BEEF;
        tick();
        res_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        checks++;
        if (rd_data !== 32'hA1) begin
            failures++;
            $display("FAIL overflow_head: got %h expected 000000a1", rd_data);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (overflow !== 1'b0 || protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: got ovf=%b perr=%b expected 0/0",
                     overflow, protocol_err);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin
                failures++;
                $display("FAIL overflow_drain[%0d]: got valid=%b data=%h expected 1/%h",
                         i, rd_valid, rd_data, exp_q[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL overflow_empty: got valid=%b ready=%b expected 0/1",
                     rd_valid, issue_ready);
        end
    endtask

    task automatic test_order_wrap();
        int issued   = 0;
        int returned = 0;
        int received = 0;
        int cyc      = 0;
        while (received < 20 && cyc < 2000) begin
            issue_valid = (issued < 20) && issue_ready && ($urandom_range(0, 3) != 0);
            res_valid   = (issued > returned) && ($urandom_range(0, 1) == 1);
            res_data    = 32'(returned + 1);
            rd_ready    = ($urandom_range(0, 1) == 1);
            #1;
            if (rd_valid && rd_ready) begin
                checks++;
                if (rd_data !== 32'(received + 1)) begin
                    failures++;
                    $display("FAIL order_word[%0d]: got %h expected %h",
                             received, rd_data, 32'(received + 1));
                end
                received++;
            end
            if (issue_valid && issue_ready) issued++;
            if (res_valid) returned++;
            tick();
            cyc++;
        end
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        rd_ready    = 1'b0;
        checks++;
        if (received != 20) begin
            failures++;
            $display("FAIL order_count: got %0d words expected 20", received);
        end
        checks++;
        if (overflow !== 1'b0 || protocol_err !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL order_final: got ovf=%b perr=%b valid=%b expected 0/0/0",
                     overflow, protocol_err, rd_valid);
        end
    endtask

    task automatic test_protocol_err();
        logic [31:0] exp_q [8];
        exp_q[0] = 32'h55;
        exp_q[1] = 32'h66;
        for (int i = 0; i < 6; i++) exp_q[i + 2] = 32'hC0 + 32'(i);
        // Unsolicited result: flagged, but still stored.
        res_valid = 1'b1;
        res_data  = 32'h55;
        tick();
        res_valid = 1'b0;
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_unsolicited: got %b expected 1", protocol_err);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h55) begin
            failures++;
            $display("FAIL perr_stored: got valid=%b data=%h expected 1/00000055",
                     rd_valid, rd_data);
        end
        // Clear and a new error in the same cycle: set wins.
        clear_err = 1'b1;
        res_valid = 1'b1;
        res_data  = 32'h66;
        tick();
        res_valid = 1'b0;
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_set_wins: got %b expected 1", protocol_err);
        end
        tick();
        clear_err = 1'b0;
        checks++;
        if (protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL perr_clear: got %b expected 0", protocol_err);
        end
        // count=2: six credits remain.
        issue_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL perr_no_credit: got issue_ready=%b expected 0", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_bad_issue: got %b expected 1", protocol_err);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_valid = 1'b1;
            res_data  = 32'hC0 + 32'(i);
            tick();
        end
        res_valid = 1'b0;
        checks++;
        if (protocol_err !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL perr_returns_clean: got perr=%b ovf=%b expected 0/0",
                     protocol_err, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin
                failures++;
                $display("FAIL perr_drain[%0d]: got valid=%b data=%h expected 1/%h",
                         i, rd_valid, rd_data, exp_q[i]);
            end
            tick();
        end
        // Empty read is ignored and is not an error.
        tick();
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || protocol_err !== 1'b0) begin
            failures++;
            $display("FAIL perr_empty_read: got valid=%b perr=%b expected 0/0",
                     rd_valid, protocol_err);
        end
        // The refused issue must not have been counted: inflight is back to 0.
        res_valid = 1'b1;
        res_data  = 32'h77;
        tick();
        res_valid = 1'b0;
        checks++;
        if (protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_inflight_zero: got %b expected 1", protocol_err);
        end
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        rd_ready    = 1'b0;
        clear_err   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        test_reset();
        test_credit_limit();
        test_full_pop();
        test_overflow();
        test_order_wrap();
        test_protocol_err();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
